debug_priv_ctrl: RTL and testbench

Multi-hart debug-mode entry and privilege-override controller with password-gated debug unlock, sitting beside each core's CSR file in the OpenPiton/Ariane SoC. Each hart may enter debug mode only when the shared authentication unit is unlocked and the dcsr ebreak enable for the hart's current privilege level is set. The hart's effective privilege is raised to M only while that hart is actually in debug mode. No other input can raise privilege. Failed password attempts are counted, and reaching the limit triggers a timed lockout.

---
 rtl/debug_priv_ctrl.sv | 168 ++++++++++++++++
 tb/tb_debug_priv_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/debug_priv_ctrl.sv
// Per-hart debug-mode entry and privilege override, gated by a shared
// password-based unlock FSM with a failure counter and timed lockout.
module debug_priv_ctrl #(
    parameter  int NUM_HARTS      = 4,
    parameter  int PW_WIDTH       = 64,
    parameter  int MAX_ATTEMPTS   = 3,
    parameter  int LOCKOUT_CYCLES = 1024,
    localparam int FCW            = $clog2(MAX_ATTEMPTS + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2*NUM_HARTS-1:0] priv_lvl_i,
    input  logic [NUM_HARTS-1:0]   ebreakm_i,
    input  logic [NUM_HARTS-1:0]   ebreaks_i,
    input  logic [NUM_HARTS-1:0]   ebreaku_i,
    input  logic [NUM_HARTS-1:0]   debug_req_i,
    input  logic [NUM_HARTS-1:0]   debug_exit_i,
    input  logic                   pw_valid_i,
    input  logic [PW_WIDTH-1:0]    pw_data_i,
    input  logic [PW_WIDTH-1:0]    pw_ref_i,
    input  logic                   relock_i,
    output logic                   pw_ready_o,
    output logic                   auth_ok_o,
    output logic                   auth_fail_o,
    output logic                   unlocked_o,
    output logic                   lockout_o,
    output logic [FCW-1:0]         fail_cnt_o,
    output logic [NUM_HARTS-1:0]   debug_mode_o,
    output logic [NUM_HARTS-1:0]   debug_deny_o,
    output logic [2*NUM_HARTS-1:0] priv_lvl_o
);

    localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        CHECK    = 2'd1,
        UNLOCKED = 2'd2,
        LOCKOUT  = 2'd3
    } auth_state_e;

    auth_state_e           state_q, state_d;
    logic [PW_WIDTH-1:0]   pw_q;
    logic [TW-1:0]         timer_q;
    logic [FCW-1:0]        fail_cnt_q;
    logic [FCW-1:0]        fail_cnt_inc;
    logic                  auth_ok_q, auth_fail_q;
    logic                  pw_match;
    logic                  hit_limit;
    logic                  clear_all;
    logic [NUM_HARTS-1:0]  debug_mode_q, debug_mode_d;
    logic [NUM_HARTS-1:0]  debug_deny_q, debug_deny_d;
    logic [NUM_HARTS-1:0]  level_en;
    logic [NUM_HARTS-1:0]  grant;

    assign pw_match     = (pw_q == pw_ref_i);
    // Saturating increment: the counter never wraps past the attempt limit.
    assign fail_cnt_inc = (fail_cnt_q == FCW'(MAX_ATTEMPTS)) ? fail_cnt_q : fail_cnt_q + FCW'(1);
    assign hit_limit    = (fail_cnt_inc == FCW'(MAX_ATTEMPTS));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= LOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKED:   if (pw_valid_i) state_d = CHECK;
            CHECK: begin
                if (pw_match)       state_d = UNLOCKED;
                else if (hit_limit) state_d = LOCKOUT;
                else                state_d = LOCKED;
            end
            UNLOCKED: if (relock_i) state_d = LOCKED;
            LOCKOUT:  if (timer_q == '0) state_d = LOCKED;
            default:  state_d = LOCKED;
        endcase
    end

    always_comb begin
        pw_ready_o  = (state_q == LOCKED);
        unlocked_o  = (state_q == UNLOCKED);
        lockout_o   = (state_q == LOCKOUT);
        auth_ok_o   = auth_ok_q;
        auth_fail_o = auth_fail_q;
        fail_cnt_o  = fail_cnt_q;
    end

    // Password holding register is wiped as soon as the comparison is done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pw_q        <= '0;
            timer_q     <= '0;
            fail_cnt_q  <= '0;
            auth_ok_q   <= 1'b0;
            auth_fail_q <= 1'b0;
        end else begin
            auth_ok_q   <= (state_q == CHECK) && pw_match;
            auth_fail_q <= (state_q == CHECK) && !pw_match;
            case (state_q)
                LOCKED: begin
                    if (pw_valid_i) pw_q <= pw_data_i;
                end
                CHECK: begin
                    pw_q <= '0;
                    if (pw_match) begin
                        fail_cnt_q <= '0;
                    end else begin
                        fail_cnt_q <= fail_cnt_inc;
                        if (hit_limit) timer_q <= TW'(LOCKOUT_CYCLES - 1);
                    end
                end
                LOCKOUT: begin
                    if (timer_q == '0) fail_cnt_q <= '0;
                    else               timer_q    <= timer_q - TW'(1);
                end
                default: ;
            endcase
        end
    end

    assign clear_all = relock_i || ((state_q == UNLOCKED) && (state_d == LOCKED));

    // Reserved privilege encoding never has an enable bit, so it always denies.
    always_comb begin
        level_en     = '0;
        grant        = '0;
        debug_deny_d = '0;
        debug_mode_d = debug_mode_q;
        priv_lvl_o   = priv_lvl_i;
        for (int h = 0; h < NUM_HARTS; h++) begin
            case (priv_lvl_i[2*h +: 2])
                2'b11:   level_en[h] = ebreakm_i[h];
                2'b01:   level_en[h] = ebreaks_i[h];
                2'b00:   level_en[h] = ebreaku_i[h];
                default: level_en[h] = 1'b0;
            endcase
            grant[h] = debug_req_i[h] && !debug_mode_q[h] && unlocked_o
                       && !relock_i && level_en[h];
            debug_deny_d[h] = debug_req_i[h] && !debug_mode_q[h] && !grant[h];
            if (clear_all)
                debug_mode_d[h] = 1'b0;
            else if (debug_mode_q[h] && debug_exit_i[h])
                debug_mode_d[h] = 1'b0;
            else if (grant[h])
                debug_mode_d[h] = 1'b1;
            if (debug_mode_q[h]) priv_lvl_o[2*h +: 2] = 2'b11;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            debug_mode_q <= '0;
            debug_deny_q <= '0;
        end else begin
            debug_mode_q <= debug_mode_d;
            debug_deny_q <= debug_deny_d;
        end
    end

    assign debug_mode_o = debug_mode_q;
    assign debug_deny_o = debug_deny_q;

endmodule

// File: tb/tb_debug_priv_ctrl.sv
// Directed self-checking bench for debug_priv_ctrl with 4 harts,
// 3 allowed failures and an 8-cycle lockout.
module tb_debug_priv_ctrl;

    localparam int NH = 4;
    localparam logic [63:0] PW_OK  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] PW_BAD = 64'h0123_4567_89AB_CDEF;

    logic        clk, rst;
    logic [7:0]  priv_lvl;
    logic [3:0]  ebreakm, ebreaks, ebreaku, debug_req, debug_exit;
    logic        pw_valid, relock;
    logic [63:0] pw_data, pw_ref;
    logic        pw_ready, auth_ok, auth_fail, unlocked, lockout;
    logic [1:0]  fail_cnt;
    logic [3:0]  debug_mode, debug_deny;
    logic [7:0]  priv_lvl_out;

    int checks   = 0;
    int failures = 0;

    debug_priv_ctrl #(
        .NUM_HARTS(NH), .PW_WIDTH(64), .MAX_ATTEMPTS(3), .LOCKOUT_CYCLES(8)
    ) dut (
        .clk_i(clk), .rst_i(rst), .priv_lvl_i(priv_lvl),
        .ebreakm_i(ebreakm), .ebreaks_i(ebreaks), .ebreaku_i(ebreaku),
        .debug_req_i(debug_req), .debug_exit_i(debug_exit),
        .pw_valid_i(pw_valid), .pw_data_i(pw_data), .pw_ref_i(pw_ref),
        .relock_i(relock), .pw_ready_o(pw_ready), .auth_ok_o(auth_ok),
        .auth_fail_o(auth_fail), .unlocked_o(unlocked), .lockout_o(lockout),
        .fail_cnt_o(fail_cnt), .debug_mode_o(debug_mode),
        .debug_deny_o(debug_deny), .priv_lvl_o(priv_lvl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic submit_pw(input logic [63:0] d);
        pw_valid = 1'b1;
        pw_data  = d;
        tick();
        pw_valid = 1'b0;
        pw_data  = '0;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; relock = 1'b0; pw_valid = 1'b0; pw_data = '0; pw_ref = PW_OK;
        priv_lvl = 8'b00_01_11_00; ebreakm = '0; ebreaks = '0; ebreaku = '0;
        debug_req = '0; debug_exit = '0;
        #3;
        checks++; if (pw_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_pw_ready got=%0b exp=1", pw_ready); end
        checks++; if (unlocked !== 1'b0) begin failures++; $display("[TB] FAIL reset_unlocked got=%0b exp=0", unlocked); end
        checks++; if (lockout !== 1'b0) begin failures++; $display("[TB] FAIL reset_lockout got=%0b exp=0", lockout); end
        checks++; if ({auth_ok, auth_fail} !== 2'b00) begin failures++; $display("[TB] FAIL reset_auth got=%b exp=00", {auth_ok, auth_fail}); end
        checks++; if (fail_cnt !== 2'd0) begin failures++; $display("[TB] FAIL reset_fail_cnt got=%0d exp=0", fail_cnt); end
        checks++; if ({debug_mode, debug_deny} !== 8'h00) begin failures++; $display("[TB] FAIL reset_debug got=%h exp=00", {debug_mode, debug_deny}); end
        checks++; if (priv_lvl_out !== 8'b00_01_11_00) begin failures++; $display("[TB] FAIL reset_priv got=%b exp=00011100", priv_lvl_out); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_locked_deny;
        priv_lvl = 8'b00_00_00_00; ebreaku = 4'b0010; debug_req = 4'b0010;
        tick();
        debug_req = '0;
        checks++; if (debug_deny !== 4'b0010) begin failures++; $display("[TB] FAIL locked_deny got=%b exp=0010", debug_deny); end
        checks++; if (debug_mode !== 4'b0000) begin failures++; $display("[TB] FAIL locked_mode got=%b exp=0000", debug_mode); end
        checks++; if (priv_lvl_out[3:2] !== 2'b00) begin failures++; $display("[TB] FAIL locked_priv1 got=%b exp=00", priv_lvl_out[3:2]); end
        tick();
        checks++; if (debug_deny !== 4'b0000) begin failures++; $display("[TB] FAIL locked_deny_pulse got=%b exp=0000", debug_deny); end
    endtask

    task automatic test_unlock;
        pw_valid = 1'b1; pw_data = PW_OK;
        tick();
        pw_valid = 1'b0; pw_data = '0;
        checks++; if (pw_ready !== 1'b0) begin failures++; $display("[TB] FAIL check_pw_ready got=%0b exp=0", pw_ready); end
        // request during CHECK: unlock lands at the same edge, must still deny
        priv_lvl = 8'b00_00_00_11; ebreakm = 4'b1111; debug_req = 4'b0001;
        tick();
        debug_req = '0;
        checks++; if ({auth_ok, auth_fail} !== 2'b10) begin failures++; $display("[TB] FAIL unlock_auth got=%b exp=10", {auth_ok, auth_fail}); end
        checks++; if (unlocked !== 1'b1) begin failures++; $display("[TB] FAIL unlock_flag got=%0b exp=1", unlocked); end
        checks++; if (fail_cnt !== 2'd0) begin failures++; $display("[TB] FAIL unlock_fail_cnt got=%0d exp=0", fail_cnt); end
        checks++; if ({debug_mode, debug_deny} !== 8'b0000_0001) begin failures++; $display("[TB] FAIL unlock_edge_deny got=%b exp=00000001", {debug_mode, debug_deny}); end
        tick();
        checks++; if ({auth_ok, unlocked, debug_deny} !== 6'b01_0000) begin failures++; $display("[TB] FAIL unlock_pulse got=%b exp=010000", {auth_ok, unlocked, debug_deny}); end
    endtask

    task automatic test_per_level;
        priv_lvl = {2'b10, 2'b11, 2'b00, 2'b01};
        ebreakm = 4'b1111; ebreaks = 4'b1110; ebreaku = 4'b1111;
        debug_req = 4'b1101;
        tick();
        debug_req = '0;
        checks++; if (debug_mode !== 4'b0100) begin failures++; $display("[TB] FAIL level_mode got=%b exp=0100", debug_mode); end
        checks++; if (debug_deny !== 4'b1001) begin failures++; $display("[TB] FAIL level_deny got=%b exp=1001", debug_deny); end
        checks++; if (priv_lvl_out !== 8'b10_11_00_01) begin failures++; $display("[TB] FAIL level_priv got=%b exp=10110001", priv_lvl_out); end
        priv_lvl = {2'b10, 2'b00, 2'b00, 2'b01};
        #1;
        checks++; if (priv_lvl_out !== 8'b10_11_00_01) begin failures++; $display("[TB] FAIL level_override got=%b exp=10110001", priv_lvl_out); end
        debug_exit = 4'b0110;
        tick();
        debug_exit = '0;
        checks++; if ({debug_mode, debug_deny} !== 8'h00) begin failures++; $display("[TB] FAIL exit_mode got=%b exp=00000000", {debug_mode, debug_deny}); end
        checks++; if (priv_lvl_out !== 8'b10_00_00_01) begin failures++; $display("[TB] FAIL exit_priv got=%b exp=10000001", priv_lvl_out); end
    endtask

    task automatic test_simultaneous;
        priv_lvl = 8'b11_11_00_11; ebreakm = 4'b1111; ebreaks = 4'b1111; ebreaku = 4'b1111;
        debug_req = 4'b0110;
        tick();
        debug_req = '0;
        checks++; if (debug_mode !== 4'b0110) begin failures++; $display("[TB] FAIL sim_enter got=%b exp=0110", debug_mode); end
        debug_req = 4'b0100; debug_exit = 4'b0100;
        tick();
        debug_req = '0; debug_exit = '0;
        checks++; if ({debug_mode, debug_deny} !== 8'b0010_0000) begin failures++; $display("[TB] FAIL sim_exit_wins got=%b exp=00100000", {debug_mode, debug_deny}); end
        relock = 1'b1; debug_req = 4'b0001;
        tick();
        relock = 1'b0; debug_req = '0;
        checks++; if ({debug_mode, debug_deny} !== 8'b0000_0001) begin failures++; $display("[TB] FAIL sim_relock got=%b exp=00000001", {debug_mode, debug_deny}); end
        checks++; if ({unlocked, pw_ready} !== 2'b01) begin failures++; $display("[TB] FAIL sim_relock_state got=%b exp=01", {unlocked, pw_ready}); end
        checks++; if (priv_lvl_out !== 8'b11_11_00_11) begin failures++; $display("[TB] FAIL sim_relock_priv got=%b exp=11110011", priv_lvl_out); end
    endtask

    task automatic test_lockout;
        for (int k = 1; k <= 3; k++) begin
            submit_pw(PW_BAD ^ 64'(k));
            checks++; if ({auth_ok, auth_fail} !== 2'b01) begin failures++; $display("[TB] FAIL lock_fail_pulse%0d got=%b exp=01", k, {auth_ok, auth_fail}); end
            checks++; if (fail_cnt !== 2'(k)) begin failures++; $display("[TB] FAIL lock_fail_cnt%0d got=%0d exp=%0d", k, fail_cnt, k); end
            checks++; if ({lockout, pw_ready} !== ((k == 3) ? 2'b10 : 2'b01)) begin failures++; $display("[TB] FAIL lock_state%0d got=%b", k, {lockout, pw_ready}); end
        end
        pw_valid = 1'b1; pw_data = PW_OK;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++; if ({lockout, pw_ready, unlocked, auth_fail, fail_cnt} !== 6'b10_0_0_11) begin failures++; $display("[TB] FAIL lock_hold%0d got=%b exp=100011", i, {lockout, pw_ready, unlocked, auth_fail, fail_cnt}); end
        end
        tick();
        pw_valid = 1'b0; pw_data = '0;
        checks++; if ({lockout, pw_ready, unlocked, fail_cnt} !== 5'b01_0_00) begin failures++; $display("[TB] FAIL lock_end got=%b exp=01000", {lockout, pw_ready, unlocked, fail_cnt}); end
        tick();
        checks++; if ({auth_ok, pw_ready} !== 2'b01) begin failures++; $display("[TB] FAIL lock_after got=%b exp=01", {auth_ok, pw_ready}); end
    endtask

    task automatic test_reset_mid;
        for (int k = 1; k <= 3; k++) submit_pw(PW_BAD);
        tick(); tick();
        checks++; if (lockout !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_lockout got=%0b exp=1", lockout); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({lockout, pw_ready, fail_cnt} !== 4'b01_00) begin failures++; $display("[TB] FAIL rst_lockout got=%b exp=0100", {lockout, pw_ready, fail_cnt}); end
        rst = 1'b0;
        tick();
        submit_pw(PW_OK);
        priv_lvl = 8'b11_11_00_11; debug_req = 4'b0001;
        tick();
        debug_req = '0;
        checks++; if (debug_mode !== 4'b0001) begin failures++; $display("[TB] FAIL rst_pre_debug got=%b exp=0001", debug_mode); end
        priv_lvl = 8'b11_11_00_01;
        #2 rst = 1'b1;
        #1;
        checks++; if ({debug_mode, unlocked, pw_ready} !== 6'b0000_01) begin failures++; $display("[TB] FAIL rst_debug got=%b exp=000001", {debug_mode, unlocked, pw_ready}); end
        checks++; if (priv_lvl_out !== 8'b11_11_00_01) begin failures++; $display("[TB] FAIL rst_priv got=%b exp=11110001", priv_lvl_out); end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_locked_deny();
        test_unlock();
        test_per_level();
        test_simultaneous();
        test_lockout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
